serial_sub4b: RTL and testbench

Bit-serial W-bit unsigned subtractor with a start/done handshake. It is the inverse-operation companion to the team's registered 4-bit adder. It latches two operands, computes A − B one bit per enabled cycle LSB-first with a rippled borrow, and presents a (W+1)-bit result whose top bit is the final borrow. It sits beside the adder in the datapath test area and shares its global `enable` hold semantics.

---
 rtl/serial_sub4b.sv | 87 ++++++++
 tb/tb_serial_sub4b.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/serial_sub4b.sv
// Bit-serial unsigned subtractor: latches A and B, ripples a borrow LSB-first
// one bit per enabled cycle, and presents {borrow, difference} on Diff.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | shifting one operand bit per enabled edge, cnt bits done so far
// DONE  | result just written to Diff, one-cycle done strobe
module serial_sub4b #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W:0]   Diff
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  a_sh, b_sh;
  // Holds the W-1 bits already produced; the bit computed on the last edge
  // goes straight into Diff, so a full W-bit collector is never needed.
  logic [W-2:0]  r_sh;
  logic          br;
  logic [CW-1:0] cnt;

  logic accept, last, d, br_nx;

  always_comb begin
    d        = a_sh[0] ^ b_sh[0] ^ br;
    br_nx    = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    accept   = enable && start && (state == IDLE || state == DONE);
    last     = (state == RUN) && (cnt == CW'(W - 1));
    state_nx = state;
    if (enable) begin
      case (state)
        IDLE:    if (start) state_nx = RUN;
        RUN:     if (last) state_nx = DONE;
        DONE:    state_nx = start ? RUN : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == RUN);
      done  <= (state_nx == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      Diff <= '0;
    end else if (accept) begin
      a_sh <= A;
      b_sh <= B;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (enable && state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= (W-1)'({d, r_sh} >> 1);
      br   <= br_nx;
      cnt  <= cnt + 1'b1;
      if (last) Diff <= {br_nx, d, r_sh};
    end
  end

endmodule

// File: tb/tb_serial_sub4b.sv
// Directed bench for serial_sub4b (W=4): reset, borrow cases, enable stall,
// back-to-back accepts and a sweep of all operand pairs.
module tb_serial_sub4b;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       start;
  logic [3:0] A, B;
  logic       busy, done;
  logic [4:0] Diff;

  int pass_cnt = 0;
  int total    = 0;

  serial_sub4b #(.W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start),
    .A(A), .B(B), .busy(busy), .done(done), .Diff(Diff)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Accept at edge k, then walk edges k+1..k+4 checking busy/done and result.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] exp);
    A = a; B = b; start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy_k"}, {busy, done}, 2'b10);
    for (int i = 1; i < 4; i++) begin
      A = 4'($urandom); B = 4'($urandom);
      step();
      check({tag, "_busy_run"}, {busy, done}, 2'b10);
    end
    step();
    check({tag, "_done"}, {busy, done}, 2'b01);
    check({tag, "_diff"}, Diff, exp);
    step();
    check({tag, "_done_low"}, done, 1'b0);
  endtask

  initial begin
    logic [4:0] exp5;
    bit         got;
    rst = 1'b0; enable = 1'b1; start = 1'b0; A = '0; B = '0;
    #3;
    check("reset_state", {busy, done, Diff}, 7'b0);
    #14 rst = 1'b1;
    step();

    run_op("basic_9_3", 4'd9, 4'd3, 5'b00110);

    // asynchronous reset partway through RUN
    A = 4'd3; B = 4'd5; start = 1'b1;
    step();
    start = 1'b0;
    step();
    #2 rst = 1'b0;
    #1 check("rst_mid_run", {busy, done, Diff}, 7'b0);
    step();
    check("rst_held", {busy, done, Diff}, 7'b0);
    #2 rst = 1'b1;
    step();
    run_op("after_rst_9_3", 4'd9, 4'd3, 5'b00110);

    run_op("b_3_5", 4'd3, 4'd5, 5'b11110);
    run_op("b_0_15", 4'd0, 4'd15, 5'b10001);
    run_op("b_15_0", 4'd15, 4'd0, 5'b01111);
    run_op("b_7_7", 4'd7, 4'd7, 5'b00000);

    // enable stall of 3 cycles after the 2nd RUN edge
    A = 4'd12; B = 4'd4; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_busy", {busy, done}, 2'b10);
    end
    enable = 1'b1;
    step();
    check("stall_k6", {busy, done}, 2'b10);
    step();
    check("stall_done_k7", {busy, done}, 2'b01);
    check("stall_diff", Diff, 5'b01000);
    enable = 1'b0;
    step();
    step();
    check("frozen_done", done, 1'b1);
    enable = 1'b1;
    step();
    check("unfrozen_done_low", done, 1'b0);

    // back-to-back with start held
    A = 4'd5; B = 4'd1; start = 1'b1;
    step();
    for (int i = 0; i < 3; i++) step();
    A = 4'd1; B = 4'd2;
    step();
    check("b2b_done1", {busy, done}, 2'b01);
    check("b2b_diff1", Diff, 5'b00100);
    step();
    start = 1'b0;
    check("b2b_accept2", {busy, done}, 2'b10);
    check("b2b_diff_held", Diff, 5'b00100);
    for (int i = 0; i < 3; i++) step();
    check("b2b_run2", {busy, done}, 2'b10);
    step();
    check("b2b_done2", {busy, done}, 2'b01);
    check("b2b_diff2", Diff, 5'b11111);
    step();

    // sweep all pairs with random enable gaps and idle spacing
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        enable = 1'b1;
        for (int g = $urandom_range(0, 2); g > 0; g--) step();
        A = 4'(a); B = 4'(b); start = 1'b1;
        step();
        start = 1'b0;
        exp5 = {1'b0, 4'(a)} - {1'b0, 4'(b)};
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
          enable = ($urandom_range(0, 3) != 0);
          step();
          if (done) got = 1'b1;
        end
        check("sweep_done_seen", got, 1'b1);
        check("sweep_diff", Diff, exp5);
        enable = 1'b1;
        step();
        check("sweep_single_pulse", done, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
